// File: rtl/vga_pkg.sv
// VGA timing package: raster parameter record, derived totals and the
// 640x480 @ 60 Hz default mode. The checker helper is only referenced
// when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

    typedef struct packed {
        int h_visible;
        int h_front;
        int h_sync;
        int h_back;
        int v_visible;
        int v_front;
        int v_sync;
        int v_back;
        int pixel_x_bits;
        int pixel_y_bits;
    } vga_params_t;

    localparam vga_params_t VGA_640x480 = '{
        h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
        pixel_x_bits: 10, pixel_y_bits: 10
    };

    function automatic int h_total(vga_params_t p);
        return p.h_visible + p.h_front + p.h_sync + p.h_back;
    endfunction

    function automatic int v_total(vga_params_t p);
        return p.v_visible + p.v_front + p.v_sync + p.v_back;
    endfunction

    // 16-pixel checkerboard cell colour for raster position (x, y)
    function automatic logic checker_bit(logic [31:0] x, logic [31:0] y);
        return x[4] ^ y[4];
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Display-path bundle between the timing generator (master) and the
// game decoder / VGA connector side (slave).
interface vga_timing_gen_if #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 10
);
    logic [X_BITS-1:0] pixel_x_target_next;
    logic [Y_BITS-1:0] pixel_y_target_next;
    logic              pixel_value_next;
    logic              h_sync;
    logic              v_sync;
    logic              vga_pixel;
    logic              frame_start;

    modport master (
        output pixel_x_target_next, pixel_y_target_next,
        output h_sync, v_sync, vga_pixel, frame_start,
        input  pixel_value_next
    );

    modport slave (
        input  pixel_x_target_next, pixel_y_target_next,
        input  h_sync, v_sync, vga_pixel, frame_start,
        output pixel_value_next
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on enable and decodes the visible
// and sync regions from the current (pre-increment) count.
module vga_axis_counter #(
    parameter int CNT_W = 10,
    parameter int VIS   = 640,
    parameter int FP    = 16,
    parameter int SYNC  = 96,
    parameter int BACK  = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active_region,
    output logic             sync_region
);
    localparam int TOTAL = VIS + FP + SYNC + BACK;

    assign wrap          = (count == CNT_W'(TOTAL - 1));
    assign active_region = (count < CNT_W'(VIS));
    assign sync_region   = (count >= CNT_W'(VIS + FP)) && (count < CNT_W'(VIS + FP + SYNC));

    // Advance the axis position on each enable, wrapping at the last position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing front end: pixel-clock divider, h/v counters, and the
// registered sync/pixel output stage (one pixel tick from coordinate to pin).
// Optional macro VGA_TEST_PATTERN_EN replaces the decoder pixel with a
// 16-pixel checkerboard.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter vga_params_t params  = VGA_640x480,
    parameter int          PIX_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = h_total(params);
    localparam int V_TOTAL = v_total(params);
    localparam int X_BITS  = params.pixel_x_bits;
    localparam int Y_BITS  = params.pixel_y_bits;

    if (X_BITS < $clog2(H_TOTAL)) begin : g_bad_x_bits
        $error("pixel_x_bits too narrow for the horizontal total");
    end
    if (Y_BITS < $clog2(V_TOTAL)) begin : g_bad_y_bits
        $error("pixel_y_bits too narrow for the vertical total");
    end
    if (PIX_DIV < 1) begin : g_bad_div
        $error("PIX_DIV must be at least 1");
    end

    logic              pix_tick;
    logic [X_BITS-1:0] h_cnt;
    logic [Y_BITS-1:0] v_cnt;
    logic              h_wrap, v_wrap;
    logic              h_active, v_active;
    logic              h_sync_region, v_sync_region;
    logic              pixel_src;
    logic              h_sync_q, v_sync_q, vga_pixel_q, frame_start_q;

    if (PIX_DIV == 1) begin : g_no_div
        assign pix_tick = 1'b1;
    end else begin : g_div
        localparam int DIV_W = $clog2(PIX_DIV);
        logic [DIV_W-1:0] div_cnt;

        assign pix_tick = (div_cnt == DIV_W'(PIX_DIV - 1));

        // Count system clocks within one pixel period
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
            end
        end
    end

    vga_axis_counter #(
        .CNT_W(X_BITS), .VIS(params.h_visible), .FP(params.h_front),
        .SYNC(params.h_sync), .BACK(params.h_back)
    ) u_h_axis (
        .clk          (clk),
        .reset        (reset),
        .enable       (pix_tick),
        .count        (h_cnt),
        .wrap         (h_wrap),
        .active_region(h_active),
        .sync_region  (h_sync_region)
    );

    vga_axis_counter #(
        .CNT_W(Y_BITS), .VIS(params.v_visible), .FP(params.v_front),
        .SYNC(params.v_sync), .BACK(params.v_back)
    ) u_v_axis (
        .clk          (clk),
        .reset        (reset),
        .enable       (pix_tick & h_wrap),
        .count        (v_cnt),
        .wrap         (v_wrap),
        .active_region(v_active),
        .sync_region  (v_sync_region)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign pixel_src = checker_bit(32'(h_cnt), 32'(v_cnt));
`else
    assign pixel_src = vga.pixel_value_next;
`endif

    // Register sync and pixel from the pre-increment coordinate; blanking forces black
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync_q    <= 1'b1;
            v_sync_q    <= 1'b1;
            vga_pixel_q <= 1'b0;
        end else if (pix_tick) begin
            h_sync_q    <= ~h_sync_region;
            v_sync_q    <= ~v_sync_region;
            vga_pixel_q <= h_active & v_active & pixel_src;
        end
    end

    // One-clock pulse after the tick on which both axes wrap back to (0,0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_tick & h_wrap & v_wrap;
        end
    end

    assign vga.pixel_x_target_next = h_cnt;
    assign vga.pixel_y_target_next = v_cnt;
    assign vga.h_sync              = h_sync_q;
    assign vga.v_sync              = v_sync_q;
    assign vga.vga_pixel           = vga_pixel_q;
    assign vga.frame_start         = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster /2, small raster /1,
// default 640x480 /2) checked every clock against a position-from-edge-count
// model, plus literal timing pins on the default mode and async reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam vga_params_t SMALL = '{
        h_visible: 20, h_front: 3, h_sync: 4, h_back: 5,
        v_visible: 20, v_front: 2, v_sync: 2, v_back: 3,
        pixel_x_bits: 5, pixel_y_bits: 5
    };

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_BITS(5),  .Y_BITS(5))  if_a ();
    vga_timing_gen_if #(.X_BITS(5),  .Y_BITS(5))  if_c ();
    vga_timing_gen_if #(.X_BITS(10), .Y_BITS(10)) if_b ();

    vga_timing_gen #(.params(SMALL), .PIX_DIV(2)) dut_a (.clk(clk), .reset(reset), .vga(if_a));
    vga_timing_gen #(.params(SMALL), .PIX_DIV(1)) dut_c (.clk(clk), .reset(reset), .vga(if_c));
    vga_timing_gen #(.params(VGA_640x480), .PIX_DIV(2)) dut_b (.clk(clk), .reset(reset), .vga(if_b));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after e rising edges since reset release.
    // Tick count t = e/div; coordinates = raster position t; pins show position t-1.
    function automatic void model(input vga_params_t p, input int div, input int e, input logic v,
                                  output int x, output int y, output logic hs, output logic vs,
                                  output logic pix, output logic fs);
        int ht = h_total(p);
        int vt = v_total(p);
        int ft = ht * vt;
        int t  = e / div;
        int q, qx, qy;
        logic vis;
        x = (t % ft) % ht;
        y = (t % ft) / ht;
        if (t == 0) begin
            hs = 1'b1; vs = 1'b1; pix = 1'b0; fs = 1'b0;
        end else begin
            q  = (t - 1) % ft;
            qx = q % ht;
            qy = q / ht;
            hs = !(qx >= p.h_visible + p.h_front && qx < p.h_visible + p.h_front + p.h_sync);
            vs = !(qy >= p.v_visible + p.v_front && qy < p.v_visible + p.v_front + p.v_sync);
            vis = (qx < p.h_visible) && (qy < p.v_visible);
`ifdef VGA_TEST_PATTERN_EN
            pix = vis && ((((qx >> 4) ^ (qy >> 4)) & 1) == 1);
`else
            pix = vis && v;
`endif
            fs = (e % div == 0) && (t % ft == 0);
        end
    endfunction

    // Model state: edges since release and the decoder value captured at each DUT's last tick
    int   e = 0;
    logic val_a = 1'b0, val_b = 1'b0, val_c = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = 0;
        end else begin
            e = e + 1;
            if (e % 2 == 0) begin
                val_a = if_a.pixel_value_next;
                val_b = if_b.pixel_value_next;
            end
            val_c = if_c.pixel_value_next;
        end
    end

    task automatic compare(input string tag, input vga_params_t p, input int div, input logic v,
                           input logic [31:0] x, input logic [31:0] y, input logic hs,
                           input logic vs, input logic pix, input logic fs);
        int ex, ey;
        logic ehs, evs, epix, efs;
        model(p, div, e, v, ex, ey, ehs, evs, epix, efs);
        check({tag, "_x"}, x, ex);
        check({tag, "_y"}, y, ey);
        check({tag, "_hsync"}, {31'b0, hs}, {31'b0, ehs});
        check({tag, "_vsync"}, {31'b0, vs}, {31'b0, evs});
        check({tag, "_pixel"}, {31'b0, pix}, {31'b0, epix});
        check({tag, "_frame_start"}, {31'b0, fs}, {31'b0, efs});
    endtask

    // Every clock, away from the active edge, compare all three instances to the model
    always @(negedge clk) begin
        compare("a", SMALL, 2, val_a, 32'(if_a.pixel_x_target_next), 32'(if_a.pixel_y_target_next),
                if_a.h_sync, if_a.v_sync, if_a.vga_pixel, if_a.frame_start);
        compare("c", SMALL, 1, val_c, 32'(if_c.pixel_x_target_next), 32'(if_c.pixel_y_target_next),
                if_c.h_sync, if_c.v_sync, if_c.vga_pixel, if_c.frame_start);
        compare("b", VGA_640x480, 2, val_b, 32'(if_b.pixel_x_target_next), 32'(if_b.pixel_y_target_next),
                if_b.h_sync, if_b.v_sync, if_b.vga_pixel, if_b.frame_start);
    end

    initial begin
        int fall = -1;
        int rise = -1;
        int pix_high = 0;
        int exp_pix_high;

        if_a.pixel_value_next = 1'b0;
        if_b.pixel_value_next = 1'b1;
        if_c.pixel_value_next = 1'b0;

        repeat (3) @(negedge clk);
        check("b_reset_hsync", {31'b0, if_b.h_sync}, 32'd1);
        check("b_reset_pixel", {31'b0, if_b.vga_pixel}, 32'd0);
        reset = 1'b1;

        // One default-mode line with the decoder tied high
        for (int n = 1; n <= 1600; n++) begin
            @(posedge clk);
            #1;
            if (fall < 0 && if_b.h_sync == 1'b0) fall = n;
            if (fall >= 0 && rise < 0 && if_b.h_sync == 1'b1) rise = n;
            if (if_b.vga_pixel == 1'b1) pix_high++;
            if_a.pixel_value_next = 1'($urandom_range(0, 1));
            if_c.pixel_value_next = 1'($urandom_range(0, 1));
        end
`ifdef VGA_TEST_PATTERN_EN
        exp_pix_high = 640;
`else
        exp_pix_high = 1280;
`endif
        check("b_hsync_fall_clk", 32'(fall), 32'd1314);
        check("b_hsync_low_clks", 32'(rise - fall), 32'd192);
        check("b_pixel_high_clks", 32'(pix_high), 32'(exp_pix_high));
        check("b_line_end_x", 32'(if_b.pixel_x_target_next), 32'd0);
        check("b_line_end_y", 32'(if_b.pixel_y_target_next), 32'd1);

        // Randomized decoder values with occasional asynchronous mid-frame resets
        for (int n = 0; n < 9000; n++) begin
            @(negedge clk);
            if_a.pixel_value_next = 1'($urandom_range(0, 1));
            if_b.pixel_value_next = 1'($urandom_range(0, 1));
            if_c.pixel_value_next = 1'($urandom_range(0, 1));
            if (n == 4321 || $urandom_range(0, 1999) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                check("async_rst_x", 32'(if_a.pixel_x_target_next), 32'd0);
                check("async_rst_y", 32'(if_a.pixel_y_target_next), 32'd0);
                check("async_rst_hsync", {31'b0, if_a.h_sync}, 32'd1);
                check("async_rst_vsync", {31'b0, if_a.v_sync}, 32'd1);
                check("async_rst_pixel", {31'b0, if_a.vga_pixel}, 32'd0);
                check("async_rst_frame_start", {31'b0, if_c.frame_start}, 32'd0);
                repeat (5) @(negedge clk);
                reset = 1'b1;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
